// File: rtl/ram_io_responder.sv
// Byte RAM + memory-mapped UART FIFOs/status/halt behind the controller's RAM bus; RAM uninitialised, INIT_FILE ignored.
// Latency: reads registered, data one cycle after address. Backpressure: TX writes dropped when full, RX held off when full.

module ram_io_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_vld,
    input  logic [7:0] push_dat,
    input  logic       pop_rdy,
    output logic [7:0] head_dat,
    output logic       empty,
    output logic       full
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        push_en;
    logic        pop_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push_en  = push_vld && !full;
    assign pop_en   = pop_rdy && !empty;
    // Empty FIFO presents zero so the head output has a defined reset value.
    assign head_dat = empty ? 8'h00 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop_en)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[PW-1:0]] <= push_dat;
    end
endmodule

module ram_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH     = 8,
    parameter     INIT_FILE      = "test.data"
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rw_req_in,
    input  logic [31:0] mem_addr_in,
    input  logic [7:0]  mem_val_in,
    output logic [7:0]  mem_val_read_out,
    output logic        io_full_out,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    output logic        sim_halt_out
);
    localparam int RAM_BYTES = 1 << RAM_ADDR_WIDTH;

    logic [7:0] ram [RAM_BYTES];

    logic [40:0]               cur_acc;
    logic [40:0]               last_acc;
    logic                      last_vld;
    logic                      new_acc;
    logic                      is_io;
    logic                      sel_data;
    logic                      sel_stat;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      tx_push;
    logic                      rx_pop;
    logic                      tx_empty;
    logic                      tx_full;
    logic                      rx_empty;
    logic                      rx_full;
    logic [7:0]                rx_head;
    logic [7:0]                rd_dat;

    // The controller holds the bus while idle, so IO side effects key off a change of access tuple.
    assign cur_acc  = {rw_req_in, mem_addr_in, mem_val_in};
    assign new_acc  = rdy_in && (!last_vld || (cur_acc != last_acc));
    assign is_io    = (mem_addr_in[17:16] == 2'b11);
    assign sel_data = is_io && (mem_addr_in[15:0] == 16'h0000);
    assign sel_stat = is_io && (mem_addr_in[15:0] == 16'h0004);
    assign ram_idx  = mem_addr_in[RAM_ADDR_WIDTH-1:0];
    assign tx_push  = new_acc && rw_req_in && sel_data;
    assign rx_pop   = new_acc && !rw_req_in && sel_data;

    ram_io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push_vld (tx_push),
        .push_dat (mem_val_in),
        .pop_rdy  (tx_ready_in),
        .head_dat (tx_data_out),
        .empty    (tx_empty),
        .full     (tx_full)
    );

    ram_io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push_vld (rx_valid_in),
        .push_dat (rx_data_in),
        .pop_rdy  (rx_pop),
        .head_dat (rx_head),
        .empty    (rx_empty),
        .full     (rx_full)
    );

    assign tx_valid_out = !tx_empty;
    assign io_full_out  = tx_full;
    assign rx_ready_out = !rx_full;

    always_comb begin
        rd_dat = 8'h00;
        if (!is_io)        rd_dat = ram[ram_idx];
        else if (sel_data) rd_dat = rx_head;
        else if (sel_stat) rd_dat = {6'b0, !rx_empty, tx_full};
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && rw_req_in && !is_io) ram[ram_idx] <= mem_val_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_val_read_out <= 8'h00;
            last_acc         <= '0;
            last_vld         <= 1'b0;
            sim_halt_out     <= 1'b0;
        end else begin
            if (rdy_in) begin
                last_acc <= cur_acc;
                last_vld <= 1'b1;
                if (!rw_req_in) mem_val_read_out <= rd_dat;
            end
            if (new_acc && rw_req_in && sel_stat) sim_halt_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_io_responder.sv
// Randomised + directed bench for ram_io_responder with a queue-based reference model and decoupled scoreboard monitor.
module tb_ram_io_responder;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic        rw_req_in = 1'b0;
    logic [31:0] mem_addr_in = '0;
    logic [7:0]  mem_val_in = '0;
    logic [7:0]  mem_val_read_out;
    logic        io_full_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in = 1'b0;
    logic [7:0]  rx_data_in = '0;
    logic        rx_valid_in = 1'b0;
    logic        rx_ready_out;
    logic        sim_halt_out;

    ram_io_responder #(.RAM_ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH), .INIT_FILE("test.data")) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .rw_req_in        (rw_req_in),
        .mem_addr_in      (mem_addr_in),
        .mem_val_in       (mem_val_in),
        .mem_val_read_out (mem_val_read_out),
        .io_full_out      (io_full_out),
        .tx_data_out      (tx_data_out),
        .tx_valid_out     (tx_valid_out),
        .tx_ready_in      (tx_ready_in),
        .rx_data_in       (rx_data_in),
        .rx_valid_in      (rx_valid_in),
        .rx_ready_out     (rx_ready_out),
        .sim_halt_out     (sim_halt_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    byte unsigned ram_m [int];
    byte unsigned mdl_tx [$];
    byte unsigned mdl_rx [$];
    bit           mdl_halt;
    int           mdl_rd;
    bit           rd_known;
    bit           l_vld;
    logic [40:0]  l_tuple;

    // Scoreboard queues and expected levels for the current cycle
    int           exp_rd_q [$];
    byte unsigned exp_tx_q [$];
    bit           exp_txv, exp_full, exp_rxr, exp_halt, exp_rdk;
    int           exp_txd, exp_rdv;
    bit           chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_exp();
        exp_txv  = (mdl_tx.size() != 0);
        exp_full = (mdl_tx.size() == DEPTH);
        exp_rxr  = (mdl_rx.size() != DEPTH);
        exp_halt = mdl_halt;
        exp_txd  = (mdl_tx.size() != 0) ? int'(mdl_tx[0]) : 0;
        exp_rdv  = mdl_rd;
        exp_rdk  = rd_known;
    endtask

    // Monitor: samples at the falling edge, away from the active edge.
    bit rd_pend = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            if (rd_pend) begin
                if (exp_rd_q.size() == 0) chk("rd_underflow", 1, 0);
                else begin
                    int e;
                    e = exp_rd_q.pop_front();
                    if (e >= 0) chk("rd_data", int'(mem_val_read_out), e);
                end
            end
            rd_pend = rdy_in && !rw_req_in;
            if (tx_valid_out && tx_ready_in) begin
                if (exp_tx_q.size() == 0) chk("tx_unexpected", int'(tx_data_out), -1);
                else chk("tx_data", int'(tx_data_out), int'(exp_tx_q.pop_front()));
            end
            chk("tx_valid", int'(tx_valid_out), int'(exp_txv));
            chk("io_full", int'(io_full_out), int'(exp_full));
            chk("rx_ready", int'(rx_ready_out), int'(exp_rxr));
            chk("sim_halt", int'(sim_halt_out), int'(exp_halt));
            chk("tx_head", int'(tx_data_out), exp_txd);
            if (exp_rdk) chk("rd_hold", int'(mem_val_read_out), exp_rdv);
        end else begin
            rd_pend = 1'b0;
        end
    end

    task automatic do_reset();
        chk_en      = 1'b0;
        rst_in      = 1'b1;
        rdy_in      = 1'b0;
        tx_ready_in = 1'b0;
        rx_valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        mdl_tx.delete();
        mdl_rx.delete();
        exp_tx_q.delete();
        exp_rd_q.delete();
        mdl_halt = 1'b0;
        mdl_rd   = 0;
        rd_known = 1'b1;
        l_vld    = 1'b0;
        set_exp();
        chk_en = 1'b1;
    endtask

    // One bus cycle: drive inputs, advance the model across the coming edge.
    task automatic cyc(input bit rdy, input bit rw, input logic [31:0] a, input logic [7:0] v,
                       input bit txr, input bit rxv, input logic [7:0] rxd);
        bit io, newa, txf, rxne, rx_ok;
        int ri, r;
        byte unsigned rxh;
        set_exp();
        rdy_in = rdy; rw_req_in = rw; mem_addr_in = a; mem_val_in = v;
        tx_ready_in = txr; rx_valid_in = rxv; rx_data_in = rxd;

        io    = (a[17:16] == 2'b11);
        ri    = int'(a & 32'h1FFFF);
        newa  = rdy && (!l_vld || ({rw, a, v} != l_tuple));
        txf   = (mdl_tx.size() == DEPTH);
        rxne  = (mdl_rx.size() != 0);
        rxh   = rxne ? mdl_rx[0] : 8'h00;
        rx_ok = rxv && (mdl_rx.size() < DEPTH);
        if (txr && mdl_tx.size() != 0) void'(mdl_tx.pop_front());
        if (rdy) begin
            if (rw) begin
                if (!io) ram_m[ri] = v;
                else if (newa && a[15:0] == 16'h0000 && !txf) begin
                    mdl_tx.push_back(v);
                    exp_tx_q.push_back(v);
                end else if (newa && a[15:0] == 16'h0004) mdl_halt = 1'b1;
            end else begin
                r = 0;
                if (!io) r = ram_m.exists(ri) ? int'(ram_m[ri]) : -1;
                else if (a[15:0] == 16'h0000) begin
                    r = int'(rxh);
                    if (newa && rxne) void'(mdl_rx.pop_front());
                end else if (a[15:0] == 16'h0004) r = {6'b0, rxne, txf};
                exp_rd_q.push_back(r);
                rd_known = (r >= 0);
                mdl_rd   = r;
            end
            l_vld   = 1'b1;
            l_tuple = {rw, a, v};
        end
        if (rx_ok) mdl_rx.push_back(rxd);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pa;
    logic [7:0]  pv;
    bit          prdy, prw;

    initial begin
        do_reset();

        // RAM write then read-back
        cyc(1, 1, 32'h0000_0010, 8'hA5, 0, 0, 0);
        cyc(1, 0, 32'h0000_0010, 8'h00, 0, 0, 0);
        cyc(0, 0, 32'h0000_0010, 8'h00, 0, 0, 0);

        // Held TX write pushes once, then a second byte
        repeat (5) cyc(1, 1, 32'h0003_0000, 8'h41, 0, 0, 0);
        cyc(1, 1, 32'h0003_0000, 8'h42, 0, 0, 0);
        repeat (4) cyc(0, 1, 32'h0003_0000, 8'h42, 1, 0, 0);

        // Fill TX FIFO past depth, read status
        for (int i = 0; i < 9; i++) cyc(1, 1, 32'h0003_0000, 8'(8'h60 + i), 0, 0, 0);
        cyc(1, 0, 32'h0003_0004, 8'h00, 0, 0, 0);
        repeat (10) cyc(0, 0, 32'h0003_0004, 8'h00, 1, 0, 0);

        // RX byte read once despite held read; fresh read returns zero
        cyc(0, 0, 32'h0, 8'h00, 0, 1, 8'h55);
        repeat (3) cyc(1, 0, 32'h0003_0000, 8'h00, 0, 0, 0);
        cyc(1, 0, 32'h0003_0004, 8'h00, 0, 0, 0);
        cyc(1, 0, 32'h0003_0000, 8'h00, 0, 0, 0);
        cyc(0, 0, 32'h0003_0000, 8'h00, 0, 0, 0);

        // rdy_in low blocks the push while the existing head drains
        cyc(1, 1, 32'h0003_0000, 8'h77, 0, 0, 0);
        repeat (3) cyc(0, 1, 32'h0003_0000, 8'h99, 1, 0, 0);

        // Halt, then reset clears it
        cyc(1, 1, 32'h0003_0004, 8'h01, 0, 0, 0);
        repeat (2) cyc(0, 0, 32'h0, 8'h00, 0, 0, 0);
        do_reset();
        cyc(0, 0, 32'h0, 8'h00, 0, 0, 0);

        // Seed the RAM pool so random reads are defined
        for (int i = 0; i < 32; i++)
            cyc(1, 1, (i >= 16 ? 32'h0001_0000 : 32'h0) | 32'(i % 16), 8'($urandom), 0, 0, 0);

        prdy = 1'b0; prw = 1'b0; pa = '0; pv = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(0, 2) != 0) begin
                prdy = ($urandom_range(0, 4) != 0);
                prw  = $urandom_range(0, 1) == 1;
                pv   = 8'($urandom);
                case ($urandom_range(0, 3))
                    0, 1: pa = ($urandom & 32'hFFFC_0000) | ($urandom_range(0, 1) == 1 ? 32'h0001_0000 : 32'h0)
                               | 32'($urandom_range(0, 15));
                    2:    pa = ($urandom & 32'hFFFC_0000) | 32'h0003_0000;
                    default: pa = ($urandom & 32'hFFFC_0000) | 32'h0003_0000
                               | ($urandom_range(0, 2) == 0 ? 32'h8 : 32'h4);
                endcase
                // Status writes would latch halt early; keep most of the run un-halted.
                if (prw && pa[17:16] == 2'b11 && pa[15:0] == 16'h4 && $urandom_range(0, 9) != 0) prw = 1'b0;
            end
            cyc(prdy, prw, pa, pv, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom));
        end

        repeat (20) cyc(0, 0, 32'h0, 8'h00, 1, 0, 0);
        chk("tx_leftover", exp_tx_q.size(), 0);
        chk("rd_leftover", exp_rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Byte-wide responder on the far side of the memory-controller RAM port: it services every byte read/write the controller drives on its RAM bus. Addresses below the IO window hit an internal byte RAM; the IO window maps a TX FIFO (toward the UART transmitter), an RX FIFO (from the UART receiver), a status byte and a simulation-halt register. Because the controller holds its RAM-bus signals when idle, IO side effects fire only on a new access.

## Interface
- RAM_ADDR_WIDTH, 17: RAM byte-address width (128 KiB, 0x00000–0x1FFFF).
- FIFO_DEPTH, 8: entries per TX/RX FIFO; power of two, ≥2.
- INIT_FILE, "test.data": hex preload file; used only with RAM_PRELOAD_EN.
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  bus enable; low = no bus access this cycle.
- rw_req_in  input  1  1 = write, 0 = read.
- mem_addr_in  input  32  byte address.
- mem_val_in  input  8  write data.
- mem_val_read_out  output  8  read data, one cycle after the address.
- io_full_out  output  1  TX FIFO full.
- tx_data_out  output  8  TX FIFO head.
- tx_valid_out  output  1  TX FIFO non-empty.
- tx_ready_in  input  1  transmitter accepts head.
- rx_data_in  input  8  received byte.
- rx_valid_in  input  1  received byte valid.
- rx_ready_out  output  1  RX FIFO not full.
- sim_halt_out  output  1  sticky halt request.

## Operation
- Decode: mem_addr_in[17:16]==2'b11 → IO; else RAM at mem_addr_in[RAM_ADDR_WIDTH-1:0]; bits above 17 ignored.
- RAM write: byte stored every write cycle (idempotent, no new-access gating).
- RAM read: byte at address registered into mem_val_read_out.
- New access: cycle with rdy_in high whose {rw_req_in, mem_addr_in, mem_val_in} differs from the last rdy_in-high cycle's tuple, or first access after reset. Last-access register updates every rdy_in-high cycle.
- IO 0x30000 write (new access): push mem_val_in to TX FIFO; dropped if full.
- IO 0x30000 read: returns RX head or 0x00 if empty; pops only on new access.
- IO 0x30004 read: {6'b0, rx_nonempty, tx_full}, pre-access state.
- IO 0x30004 write (new access): sim_halt_out ← 1 until reset.
- Other IO addresses: writes ignored, reads 0x00.
- TX pop: tx_valid_out && tx_ready_in. RX push: rx_valid_in && rx_ready_out.
- FIFO handshakes run regardless of rdy_in; rdy_in low blocks RAM/IO access only, mem_val_read_out holds.
- FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap modulo 2·FIFO_DEPTH; full = MSBs differ, low bits equal.

## Timing
- Reset values: mem_val_read_out 0, tx_data_out 0, tx_valid_out 0, io_full_out 0, rx_ready_out 1, sim_halt_out 0; FIFOs empty; last-access cleared. RAM contents not reset.
- Read latency 1: address at edge N → mem_val_read_out valid after edge N+1, stable until next rdy_in-high read.
- Write cycle: mem_val_read_out holds.
- Read and write of same RAM byte on consecutive cycles: read returns new value.
- TX push at edge N → tx_valid_out high after N (no bypass; empty FIFO shows data one cycle after push).
- Push+pop same cycle: full → push dropped (full sampled pre-edge), pop proceeds; empty → only push takes effect; otherwise count unchanged.
- RX push+pop same cycle on full RX FIFO: rx_ready_out was 0, so only pop.
- io_full_out, rx_ready_out, tx_valid_out derive from registered pointers.
- Reset mid-transfer: FIFOs flush, in-flight bytes lost, halt cleared.

## Configuration
- RAM_PRELOAD_EN defined: RAM initialised from INIT_FILE (hex, one byte per word) at time zero.
- Undefined: no preload, RAM uninitialised, INIT_FILE ignored; all else identical.

## Test plan
- Write 0xA5 to 0x00010, read 0x00010 next cycle → mem_val_read_out = 0xA5 one cycle later.
- Write 0x41 to 0x30000 held 5 cycles, then 0x42 → exactly two TX entries, tx_data_out 0x41 then 0x42 with tx_ready_in high.
- tx_ready_in low, 9 distinct writes to 0x30000 (DEPTH 8) → io_full_out high after 8th, 9th dropped, status read = 0x01.
- rx_valid_in with 0x55, read 0x30000 held 3 cycles → returns 0x55 once, popped once; fresh read → 0x00.
- Write 0x30004 → sim_halt_out 1; rst_in pulse → 0, all outputs at reset values.
- rdy_in low with TX write and tx_ready_in high → no push, existing head still drains.
